// File: rtl/copy_axi4_rd_burst.sv
// Read-side AXI4 INCR burst master feeding the copy engine's cache write port.
// Optional 4KB burst splitting is enabled by defining COPY_AXI4_RD_4K_SPLIT_EN.
module copy_axi4_rd_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [8:0]        req_beats,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int                BYTES      = DATA_W / 8;
  localparam int                SIZE_LOG2  = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] BEAT_INC   = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
  localparam logic [1:0]        RESP_OKAY  = 2'b00;
  localparam logic [1:0]        BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_DATA,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] wr_addr_inc;
  logic [7:0]        arlen_q;
  logic [8:0]        cnt_q;
  logic              err_q;
  logic              drain_q;
  logic              req_bad;
  logic              xfer;
  logic              resp_bad;
  logic              cnt_last;
  logic              burst_end;
  logic              more_bursts;

`ifdef COPY_AXI4_RD_4K_SPLIT_EN
  logic [8:0] rem_q;
  logic [8:0] first_chunk;
  logic [8:0] next_chunk;

  // Beats that fit between a byte offset and the next 4KB boundary, capped at one AXI burst.
  function automatic logic [8:0] beats_to_4k(input logic [11:0] offs);
    logic [12:0] room;
    room = (13'h1000 - {1'b0, offs}) >> SIZE_LOG2;
    if (room > 13'(MAX_BEATS)) room = 13'(MAX_BEATS);
    return room[8:0];
  endfunction

  function automatic logic [8:0] chunk_beats(input logic [11:0] offs, input logic [8:0] left);
    logic [8:0] room;
    room = beats_to_4k(offs);
    return (left < room) ? left : room;
  endfunction

  assign first_chunk = chunk_beats(req_addr[11:0], req_beats);
  assign next_chunk  = chunk_beats(wr_addr_inc[11:0], rem_q);
  assign more_bursts = (rem_q != 9'd0);
`else
  function automatic logic crosses_4k(input logic [11:0] offs, input logic [8:0] beats);
    logic [17:0] end_off;
    end_off = {6'd0, offs} + ({9'd0, beats} << SIZE_LOG2);
    return end_off > 18'h1000;
  endfunction

  assign more_bursts = 1'b0;
`endif

  always_comb begin
    req_bad = (req_beats == 9'd0) || (req_beats > 9'(MAX_BEATS)) ||
              (|(req_addr & ALIGN_MASK));
`ifndef COPY_AXI4_RD_4K_SPLIT_EN
    if (crosses_4k(req_addr[11:0], req_beats)) req_bad = 1'b1;
`endif
  end

  assign wr_addr_inc = wr_addr_q + BEAT_INC;
  assign resp_bad    = (rresp != RESP_OKAY);
  assign cnt_last    = (cnt_q == 9'd1);
  assign xfer        = (state == S_DATA) && rvalid && rready;
  assign burst_end   = xfer && (cnt_last || rlast);

  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = 3'(SIZE_LOG2);
  assign arburst = BURST_INCR;
  assign wr_addr = wr_addr_q;
  assign wr_data = rdata;
  assign err     = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    wr_valid  = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = req_bad ? S_DONE : S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_DATA;
      end
      S_DATA: begin
        // Once a bad response is seen, keep accepting beats but stop writing the cache.
        rready   = drain_q || wr_ready;
        wr_valid = rvalid && !drain_q && !resp_bad;
        if (burst_end) state_nxt = (cnt_last && more_bursts) ? S_AR : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      araddr_q  <= '0;
      arlen_q   <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      drain_q   <= 1'b0;
`ifdef COPY_AXI4_RD_4K_SPLIT_EN
      rem_q     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            araddr_q  <= req_addr;
            wr_addr_q <= req_addr;
            err_q     <= req_bad;
            drain_q   <= 1'b0;
`ifdef COPY_AXI4_RD_4K_SPLIT_EN
            arlen_q   <= 8'(first_chunk - 9'd1);
            rem_q     <= req_beats - first_chunk;
`else
            arlen_q   <= 8'(req_beats - 9'd1);
`endif
          end
        end
        S_AR: begin
          if (arready) cnt_q <= {1'b0, arlen_q} + 9'd1;
        end
        S_DATA: begin
          if (xfer) begin
            wr_addr_q <= wr_addr_inc;
            cnt_q     <= cnt_q - 9'd1;
            if (resp_bad) begin
              err_q   <= 1'b1;
              drain_q <= 1'b1;
            end
            // RLAST must coincide exactly with the counted final beat.
            if (rlast != cnt_last) err_q <= 1'b1;
`ifdef COPY_AXI4_RD_4K_SPLIT_EN
            if (cnt_last && more_bursts) begin
              araddr_q <= wr_addr_inc;
              arlen_q  <= 8'(next_chunk - 9'd1);
              rem_q    <= rem_q - next_chunk;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_copy_axi4_rd_burst.sv
// Self-checking bench for copy_axi4_rd_burst: AXI read slave, cache sink and a
// transaction-level reference model of the expected ARs, writes and error status.
module tb_copy_axi4_rd_burst;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [8:0]        req_beats;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              done, err, busy;

  always #5 clk = ~clk;

  copy_axi4_rd_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(256)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_beats(req_beats),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .err(err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Slave / sink behaviour knobs
  int cfg_bad_beat;   // 1-based beat index answered with SLVERR, 0 = none
  int cfg_rlast_at;   // -1 natural per burst, 0 never, n = on global beat n
  int cfg_wr_mode;    // 0 always ready, 1 three-cycle stall after 2 writes, 2 random
  bit cfg_ar_rand;
  bit cfg_rv_rand;

  logic [DATA_W-1:0] beat_data [0:511];

  logic [31:0] obs_ar_addr[$];
  int          obs_ar_len[$];
  logic [31:0] obs_wr_addr[$];
  logic [63:0] obs_wr_data[$];
  int obs_done, obs_ar_bad, obs_ready_viol;
  logic obs_err_done, obs_err_after;
  bit obs_timeout;

  logic [31:0] exp_ar_addr[$];
  int          exp_ar_len[$];
  logic [31:0] exp_wr_addr[$];
  int          exp_wr_idx[$];
  logic        exp_err;

  task automatic set_cfg(input int bad, input int rl, input int wm, input bit ar_r, input bit rv_r);
    cfg_bad_beat = bad; cfg_rlast_at = rl; cfg_wr_mode = wm; cfg_ar_rand = ar_r; cfg_rv_rand = rv_r;
  endtask

  // Drives one request and plays AXI slave and cache sink until two cycles after done.
  task automatic run_req(input logic [31:0] a, input logic [8:0] n, input int stop_after_wr);
    int pend_len[$];
    int burst_left = 0, burst_pos = 0, burst_len = 0, gidx = 0;
    int cyc = 0, post = -1, stall_left = 3;
    bit req_on = 1'b1, ar_hold = 1'b0;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;
    obs_ar_addr.delete(); obs_ar_len.delete(); obs_wr_addr.delete(); obs_wr_data.delete();
    obs_done = 0; obs_ar_bad = 0; obs_ready_viol = 0; obs_timeout = 1'b0;
    obs_err_done = 1'bx; obs_err_after = 1'bx;
    for (int i = 0; i < 512; i++) beat_data[i] = {$urandom, $urandom};
    while (1) begin
      @(negedge clk);
      req_valid = req_on; req_addr = a; req_beats = n;
      arready = cfg_ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (burst_left == 0 && pend_len.size() > 0) begin
        burst_len = pend_len.pop_front(); burst_left = burst_len; burst_pos = 0;
      end
      if (burst_left > 0 && (!cfg_rv_rand || $urandom_range(0, 3) != 0)) begin
        rvalid = 1'b1;
        rdata  = beat_data[gidx];
        rresp  = (gidx + 1 == cfg_bad_beat) ? 2'b10 : 2'b00;
        rlast  = (cfg_rlast_at < 0) ? (burst_pos == burst_len - 1)
                                    : (cfg_rlast_at > 0 && gidx + 1 == cfg_rlast_at);
      end else begin
        rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
      end
      case (cfg_wr_mode)
        1: begin
          wr_ready = 1'b1;
          if (obs_wr_addr.size() == 2 && stall_left > 0) begin wr_ready = 1'b0; stall_left--; end
        end
        2:       wr_ready = ($urandom_range(0, 2) != 0);
        default: wr_ready = 1'b1;
      endcase
      #1;
      if (req_valid && req_ready) req_on = 1'b0;
      if (arvalid) begin
        if (arsize !== 3'd3 || arburst !== 2'b01) obs_ar_bad++;
        if (ar_hold && (araddr !== hold_addr || arlen !== hold_len)) obs_ar_bad++;
        if (arready) begin
          obs_ar_addr.push_back(araddr); obs_ar_len.push_back(int'(arlen));
          pend_len.push_back(int'(arlen) + 1); ar_hold = 1'b0;
        end else begin
          ar_hold = 1'b1; hold_addr = araddr; hold_len = arlen;
        end
      end
      if (rvalid && rready) begin gidx++; burst_pos++; burst_left--; end
      if (wr_ready === 1'b0 && rready === 1'b1) obs_ready_viol++;
      if (wr_valid && wr_ready) begin obs_wr_addr.push_back(wr_addr); obs_wr_data.push_back(wr_data); end
      if (done) begin obs_done++; obs_err_done = err; end
      if (post < 0 && done) post = 2;
      else if (post > 0) begin
        post--; obs_err_after = err;
        if (post == 0) break;
      end
      if (stop_after_wr > 0 && obs_wr_addr.size() >= stop_after_wr) return;
      cyc++;
      if (cyc > 3000) begin obs_timeout = 1'b1; break; end
    end
    req_valid = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; wr_ready = 1'b1;
  endtask

  // Reference model: what a request should produce, from the address/beat rules alone.
  task automatic model_req(input logic [31:0] a, input int n);
    int left, c, room, consumed;
    logic [31:0] cur;
    bit ok;
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_wr_addr.delete(); exp_wr_idx.delete();
    ok = (n >= 1) && (n <= 256) && (a[2:0] == 3'd0);
`ifndef COPY_AXI4_RD_4K_SPLIT_EN
    if (int'(a[11:0]) + n * 8 > 4096) ok = 1'b0;
`endif
    if (!ok) begin exp_err = 1'b1; return; end
`ifdef COPY_AXI4_RD_4K_SPLIT_EN
    cur = a; left = n;
    while (left > 0) begin
      room = (4096 - int'(cur[11:0])) / 8;
      c = (left < room) ? left : room;
      exp_ar_addr.push_back(cur); exp_ar_len.push_back(c - 1);
      cur = cur + 32'(c * 8); left = left - c;
    end
`else
    exp_ar_addr.push_back(a); exp_ar_len.push_back(n - 1);
`endif
    consumed = (cfg_rlast_at > 0 && cfg_rlast_at < n) ? cfg_rlast_at : n;
    for (int i = 0; i < consumed; i++)
      if (cfg_bad_beat == 0 || i + 1 < cfg_bad_beat) begin
        exp_wr_addr.push_back(a + 32'(i * 8)); exp_wr_idx.push_back(i);
      end
    exp_err = (cfg_bad_beat >= 1 && cfg_bad_beat <= consumed) || (cfg_rlast_at >= 0 && cfg_rlast_at != n);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({req_ready, arvalid, rready, wr_valid, done, err, busy} !== 7'b1000000) begin
      errors++; $display("FAIL reset_ctrl got %b expected 1000000", {req_ready, arvalid, rready, wr_valid, done, err, busy});
    end
    checks++;
    if (araddr !== 32'd0 || arlen !== 8'd0 || wr_addr !== 32'd0) begin
      errors++; $display("FAIL reset_addr got %h/%h/%h expected 0/0/0", araddr, arlen, wr_addr);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic;
    set_cfg(0, -1, 0, 1'b0, 1'b0);
    run_req(32'h1000, 9'd4, 0);
    model_req(32'h1000, 4);
    checks++;
    if (obs_timeout || obs_ar_addr.size() != 1 || obs_ar_addr[0] !== 32'h1000 || obs_ar_len[0] != 3) begin
      errors++; $display("FAIL basic_ar got n=%0d addr=%h len=%0d to=%0d expected n=1 addr=1000 len=3",
        obs_ar_addr.size(), (obs_ar_addr.size() > 0) ? obs_ar_addr[0] : 32'hx,
        (obs_ar_len.size() > 0) ? obs_ar_len[0] : -1, obs_timeout);
    end
    checks++;
    if (obs_ar_bad != 0) begin errors++; $display("FAIL basic_ar_attr got %0d bad expected 0", obs_ar_bad); end
    checks++;
    if (obs_wr_addr.size() != 4) begin errors++; $display("FAIL basic_wr_count got %0d expected 4", obs_wr_addr.size()); end
    for (int i = 0; i < 4 && i < obs_wr_addr.size(); i++) begin
      checks++;
      if (obs_wr_addr[i] !== 32'h1000 + 32'(i * 8) || obs_wr_data[i] !== beat_data[i]) begin
        errors++; $display("FAIL basic_wr[%0d] got %h/%h expected %h/%h", i, obs_wr_addr[i], obs_wr_data[i],
          32'h1000 + 32'(i * 8), beat_data[i]);
      end
    end
    checks++;
    if (obs_done != 1 || obs_err_done !== 1'b0) begin
      errors++; $display("FAIL basic_done got done=%0d err=%b expected 1/0", obs_done, obs_err_done);
    end
  endtask

  task automatic test_stall;
    set_cfg(0, -1, 1, 1'b0, 1'b0);
    run_req(32'h1000, 9'd4, 0);
    model_req(32'h1000, 4);
    checks++;
    if (obs_ready_viol != 0) begin errors++; $display("FAIL stall_rready got %0d cycles expected 0", obs_ready_viol); end
    checks++;
    if (obs_wr_addr.size() != exp_wr_addr.size()) begin
      errors++; $display("FAIL stall_wr_count got %0d expected %0d", obs_wr_addr.size(), exp_wr_addr.size());
    end
    for (int i = 0; i < exp_wr_addr.size() && i < obs_wr_addr.size(); i++) begin
      checks++;
      if (obs_wr_addr[i] !== exp_wr_addr[i] || obs_wr_data[i] !== beat_data[exp_wr_idx[i]]) begin
        errors++; $display("FAIL stall_wr[%0d] got %h/%h expected %h/%h", i, obs_wr_addr[i], obs_wr_data[i],
          exp_wr_addr[i], beat_data[exp_wr_idx[i]]);
      end
    end
    checks++;
    if (obs_done != 1 || obs_err_done !== 1'b0) begin
      errors++; $display("FAIL stall_done got done=%0d err=%b expected 1/0", obs_done, obs_err_done);
    end
  endtask

  task automatic test_slverr;
    set_cfg(3, -1, 0, 1'b0, 1'b0);
    run_req(32'h2000, 9'd8, 0);
    model_req(32'h2000, 8);
    checks++;
    if (obs_wr_addr.size() != 2) begin errors++; $display("FAIL slverr_wr_count got %0d expected 2", obs_wr_addr.size()); end
    for (int i = 0; i < exp_wr_addr.size() && i < obs_wr_addr.size(); i++) begin
      checks++;
      if (obs_wr_addr[i] !== exp_wr_addr[i] || obs_wr_data[i] !== beat_data[exp_wr_idx[i]]) begin
        errors++; $display("FAIL slverr_wr[%0d] got %h expected %h", i, obs_wr_addr[i], exp_wr_addr[i]);
      end
    end
    checks++;
    if (obs_done != 1 || obs_err_done !== 1'b1 || obs_err_after !== 1'b1) begin
      errors++; $display("FAIL slverr_done got done=%0d err=%b held=%b expected 1/1/1", obs_done, obs_err_done, obs_err_after);
    end
  endtask

  task automatic test_rlast;
    set_cfg(0, 2, 0, 1'b0, 1'b0);
    run_req(32'h3000, 9'd4, 0);
    checks++;
    if (obs_wr_addr.size() != 2 || obs_done != 1 || obs_err_done !== 1'b1) begin
      errors++; $display("FAIL early_rlast got wr=%0d done=%0d err=%b expected 2/1/1", obs_wr_addr.size(), obs_done, obs_err_done);
    end
    set_cfg(0, -1, 0, 1'b0, 1'b0);
    run_req(32'h3100, 9'd4, 0);
    checks++;
    if (obs_wr_addr.size() != 4 || obs_done != 1 || obs_err_done !== 1'b0 || obs_wr_addr[3] !== 32'h3118) begin
      errors++; $display("FAIL after_rlast got wr=%0d done=%0d err=%b expected 4/1/0", obs_wr_addr.size(), obs_done, obs_err_done);
    end
    set_cfg(0, 0, 0, 1'b0, 1'b0);
    run_req(32'h3200, 9'd3, 0);
    checks++;
    if (obs_wr_addr.size() != 3 || obs_done != 1 || obs_err_done !== 1'b1) begin
      errors++; $display("FAIL missing_rlast got wr=%0d done=%0d err=%b expected 3/1/1", obs_wr_addr.size(), obs_done, obs_err_done);
    end
  endtask

  task automatic test_bad_req;
    logic [31:0] addrs [0:1];
    int          beats [0:1];
    addrs[0] = 32'h1000; beats[0] = 0;
    addrs[1] = 32'h1004; beats[1] = 2;
    set_cfg(0, -1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      run_req(addrs[k], 9'(beats[k]), 0);
      checks++;
      if (obs_ar_addr.size() != 0 || obs_wr_addr.size() != 0 || obs_done != 1 || obs_err_done !== 1'b1) begin
        errors++; $display("FAIL bad_req[%0d] got ar=%0d wr=%0d done=%0d err=%b expected 0/0/1/1",
          k, obs_ar_addr.size(), obs_wr_addr.size(), obs_done, obs_err_done);
      end
    end
  endtask

  task automatic test_4k;
    set_cfg(0, -1, 0, 1'b1, 1'b0);
    run_req(32'h0FF0, 9'd4, 0);
    model_req(32'h0FF0, 4);
    checks++;
    if (obs_ar_addr.size() != exp_ar_addr.size()) begin
      errors++; $display("FAIL cross4k_ar_count got %0d expected %0d", obs_ar_addr.size(), exp_ar_addr.size());
    end
    for (int i = 0; i < exp_ar_addr.size() && i < obs_ar_addr.size(); i++) begin
      checks++;
      if (obs_ar_addr[i] !== exp_ar_addr[i] || obs_ar_len[i] != exp_ar_len[i]) begin
        errors++; $display("FAIL cross4k_ar[%0d] got %h/%0d expected %h/%0d", i, obs_ar_addr[i], obs_ar_len[i],
          exp_ar_addr[i], exp_ar_len[i]);
      end
    end
    checks++;
    if (obs_wr_addr.size() != exp_wr_addr.size() || obs_done != 1 || obs_err_done !== exp_err || obs_ar_bad != 0) begin
      errors++; $display("FAIL cross4k_done got wr=%0d done=%0d err=%b attr=%0d expected %0d/1/%b/0",
        obs_wr_addr.size(), obs_done, obs_err_done, obs_ar_bad, exp_wr_addr.size(), exp_err);
    end
    run_req(32'h0FE0, 9'd4, 0);
    checks++;
    if (obs_ar_addr.size() != 1 || obs_ar_len[0] != 3 || obs_err_done !== 1'b0) begin
      errors++; $display("FAIL edge4k got ar=%0d err=%b expected 1/0", obs_ar_addr.size(), obs_err_done);
    end
  endtask

  task automatic test_reset_mid;
    set_cfg(0, -1, 0, 1'b0, 1'b0);
    run_req(32'h4000, 9'd8, 3);
    checks++;
    if (busy !== 1'b1 || wr_valid !== 1'b1) begin
      errors++; $display("FAIL mid_busy got busy=%b wr_valid=%b expected 1/1", busy, wr_valid);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({req_ready, arvalid, rready, wr_valid, done, err, busy} !== 7'b1000000 ||
        araddr !== 32'd0 || arlen !== 8'd0 || wr_addr !== 32'd0) begin
      errors++; $display("FAIL mid_reset got %b %h %h %h expected 1000000 0 0 0",
        {req_ready, arvalid, rready, wr_valid, done, err, busy}, araddr, arlen, wr_addr);
    end
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    rstn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_release got req_ready=%b expected 1", req_ready); end
    run_req(32'h4100, 9'd4, 0);
    checks++;
    if (obs_wr_addr.size() != 4 || obs_wr_addr[0] !== 32'h4100 || obs_done != 1 || obs_err_done !== 1'b0) begin
      errors++; $display("FAIL mid_fresh got wr=%0d done=%0d err=%b expected 4/1/0", obs_wr_addr.size(), obs_done, obs_err_done);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    int n, bad, mism;
    for (int t = 0; t < 15; t++) begin
      a   = {18'd0, 11'($urandom_range(0, 2047)), 3'b000};
      n   = $urandom_range(1, 64);
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      set_cfg(bad, -1, 2, 1'b1, 1'b1);
      run_req(a, 9'(n), 0);
      model_req(a, n);
      mism = 0;
      if (obs_ar_addr.size() != exp_ar_addr.size()) mism++;
      else for (int i = 0; i < exp_ar_addr.size(); i++)
        if (obs_ar_addr[i] !== exp_ar_addr[i] || obs_ar_len[i] != exp_ar_len[i]) mism++;
      checks++;
      if (mism != 0 || obs_ar_bad != 0) begin
        errors++; $display("FAIL rand%0d_ar addr=%h beats=%0d got n=%0d attr=%0d expected n=%0d", t, a, n,
          obs_ar_addr.size(), obs_ar_bad, exp_ar_addr.size());
      end
      mism = 0;
      if (obs_wr_addr.size() != exp_wr_addr.size()) mism++;
      else for (int i = 0; i < exp_wr_addr.size(); i++)
        if (obs_wr_addr[i] !== exp_wr_addr[i] || obs_wr_data[i] !== beat_data[exp_wr_idx[i]]) mism++;
      checks++;
      if (mism != 0) begin
        errors++; $display("FAIL rand%0d_wr addr=%h beats=%0d bad=%0d got %0d writes expected %0d", t, a, n, bad,
          obs_wr_addr.size(), exp_wr_addr.size());
      end
      checks++;
      if (obs_timeout || obs_done != 1 || obs_err_done !== exp_err || obs_err_after !== exp_err) begin
        errors++; $display("FAIL rand%0d_done got done=%0d err=%b held=%b to=%0d expected 1/%b/%b/0", t,
          obs_done, obs_err_done, obs_err_after, obs_timeout, exp_err, exp_err);
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_beats = '0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; wr_ready = 1'b1;
    set_cfg(0, -1, 0, 1'b0, 1'b0);
    test_reset;
    test_basic;
    test_stall;
    test_slverr;
    test_rlast;
    test_bad_req;
    test_4k;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
